// File: rtl/mul_div_pkg.sv
// Shared definitions for the signed multiply/divide unit.
//   WIDTH / ITER   operand width and number of CALC iterations
//   OP_MUL/OP_DIV  encodings of the op input
//   state_t        sequencer states
//   magnitude()    two's-complement absolute value (0x80000000 maps to
//                  itself, which is the correct unsigned magnitude)
package mul_div_pkg;

    localparam int WIDTH = 32;
    localparam int ITER  = 32;
    localparam int CNT_W = 6;

    localparam logic OP_MUL = 1'b0;
    localparam logic OP_DIV = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? -v : v;
    endfunction

endpackage

// File: rtl/mul_div_unit_if.sv
// Request/result bundle of the multiply/divide unit.
//   start, op, a, b          request side (driven by the master)
//   busy, done, zhigh, zlow,
//   div_by_zero              status and result side (driven by the unit)
interface mul_div_unit_if;
    import mul_div_pkg::*;

    logic             start;
    logic             op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] zhigh;
    logic [WIDTH-1:0] zlow;
    logic             div_by_zero;

    modport master (
        output start, op, a, b,
        input  busy, done, zhigh, zlow, div_by_zero
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, zhigh, zlow, div_by_zero
    );

endinterface

// File: rtl/mul_div_unit.sv
// Iterative 32x32 signed multiply (radix-2 Booth) and signed divide
// (restoring, on magnitudes) sharing one 64-bit accumulator and one
// 6-bit iteration counter.
//
// Ports
//   clk   system clock, rising edge
//   rst   synchronous active-high clear, wins over start
//   bus   mul_div_unit_if.slave: start/op/a/b in, busy/done/zhigh/zlow/
//         div_by_zero out
//
// State | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start
// CALC  | one Booth or restoring-divide step per cycle, 32 cycles
// FIX   | sign correction, load zhigh/zlow
// DONE  | result valid; start here is accepted like in IDLE
//
// busy and done are registered decodes of the state and therefore lag the
// state by one cycle: done pulses 34 edges after the start-sampling edge
// (1 edge for a zero divisor), busy is low in that cycle. zhigh/zlow are
// loaded on entry to DONE and are already stable when done rises.
module mul_div_unit
    import mul_div_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    mul_div_unit_if.slave  bus
);

    state_t               state;
    logic                 op_q;
    logic [WIDTH-1:0]     mcand;      // multiplicand (mul) or divisor magnitude (div)
    logic [2*WIDTH-1:0]   acc;        // mul: {partial product, multiplier}; div: {remainder, quotient}
    logic                 qm1;        // Booth look-behind bit
    logic [CNT_W-1:0]     cnt;
    logic                 q_neg;
    logic                 r_neg;
    logic                 dz_flag;

    logic                 busy_q;
    logic                 done_q;
    logic                 dbz_q;
    logic [WIDTH-1:0]     zhigh_q;
    logic [WIDTH-1:0]     zlow_q;

    logic                 accept;
    logic [WIDTH:0]       booth_sum;
    logic [WIDTH:0]       rem_shift;
    logic [WIDTH:0]       rem_diff;
    logic [2*WIDTH-1:0]   acc_step;
    logic [WIDTH-1:0]     fix_hi;
    logic [WIDTH-1:0]     fix_lo;

    assign accept = bus.start && ((state == IDLE) || (state == DONE));

    // One iteration of the active algorithm. The Booth add is done in 33
    // bits so that subtracting 0x80000000 cannot overflow; after the
    // arithmetic shift the upper half always fits back into 32 bits.
    always_comb begin
        booth_sum = {acc[2*WIDTH-1], acc[2*WIDTH-1:WIDTH]};
        rem_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        rem_diff  = rem_shift - {1'b0, mcand};
        acc_step  = acc;
        if (op_q == OP_MUL) begin
            case ({acc[0], qm1})
                2'b01:   booth_sum = {acc[2*WIDTH-1], acc[2*WIDTH-1:WIDTH]} + {mcand[WIDTH-1], mcand};
                2'b10:   booth_sum = {acc[2*WIDTH-1], acc[2*WIDTH-1:WIDTH]} - {mcand[WIDTH-1], mcand};
                default: ;
            endcase
            acc_step = {booth_sum, acc[WIDTH-1:1]};
        end else begin
            // Remainder stays below the divisor (<= 2^31), so the shifted
            // value fits 32 bits and bit 32 of the difference is the borrow.
            if (!rem_diff[WIDTH]) begin
                acc_step = {rem_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            end else begin
                acc_step = {rem_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
            end
        end
    end

    // Quotient takes the XOR of operand signs, remainder the dividend sign.
    always_comb begin
        fix_hi = acc[2*WIDTH-1:WIDTH];
        fix_lo = acc[WIDTH-1:0];
        if (op_q == OP_DIV) begin
            fix_lo = q_neg ? -acc[WIDTH-1:0]       : acc[WIDTH-1:0];
            fix_hi = r_neg ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            op_q    <= OP_MUL;
            mcand   <= '0;
            acc     <= '0;
            qm1     <= 1'b0;
            cnt     <= '0;
            q_neg   <= 1'b0;
            r_neg   <= 1'b0;
            dz_flag <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
            zhigh_q <= '0;
            zlow_q  <= '0;
        end else begin
            busy_q <= (state == CALC) || (state == FIX);
            done_q <= (state == DONE);

            // The flag travels with the done pulse of its own operation.
            if (state == DONE) begin
                dbz_q <= dz_flag;
            end else if (accept) begin
                dbz_q <= 1'b0;
            end

            case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        op_q    <= bus.op;
                        cnt     <= '0;
                        qm1     <= 1'b0;
                        dz_flag <= 1'b0;
                        q_neg   <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
                        r_neg   <= bus.a[WIDTH-1];
                        if (bus.op == OP_MUL) begin
                            mcand <= bus.a;
                            acc   <= {{WIDTH{1'b0}}, bus.b};
                            state <= CALC;
                        end else if (bus.b == '0) begin
                            mcand   <= '0;
                            acc     <= '0;
                            dz_flag <= 1'b1;
                            zhigh_q <= bus.a;
                            zlow_q  <= '1;
                            state   <= DONE;
                        end else begin
                            mcand <= magnitude(bus.b);
                            acc   <= {{WIDTH{1'b0}}, magnitude(bus.a)};
                            state <= CALC;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                CALC: begin
                    acc <= acc_step;
                    qm1 <= acc[0];
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(ITER - 1)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    zhigh_q <= fix_hi;
                    zlow_q  <= fix_lo;
                    state   <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.div_by_zero = dbz_q;
    assign bus.zhigh       = zhigh_q;
    assign bus.zlow        = zlow_q;

endmodule

// File: tb/tb_mul_div_unit.sv
module tb_mul_div_unit;
    import mul_div_pkg::*;

    logic clk = 1'b0;
    logic rst;

    mul_div_unit_if bus();

    mul_div_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int unsigned due;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        mon_e;
    int          checks   = 0;
    int          failures = 0;
    int unsigned cyc      = 0;
    logic [31:0] last_hi;
    logic [31:0] last_lo;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: plain 64-bit signed arithmetic; SV '/' truncates toward
    // zero and '%' takes the dividend's sign.
    function automatic exp_t model(input logic op, input logic [31:0] a, input logic [31:0] b);
        exp_t   e;
        longint sa, sb, p, q, r;
        sa    = longint'($signed(a));
        sb    = longint'($signed(b));
        e.dz  = 1'b0;
        e.due = 0;
        if (op == OP_MUL) begin
            p    = sa * sb;
            e.hi = p[63:32];
            e.lo = p[31:0];
        end else if (b == 32'd0) begin
            e.hi = a;
            e.lo = 32'hFFFF_FFFF;
            e.dz = 1'b1;
        end else begin
            q    = sa / sb;
            r    = sa % sb;
            e.lo = q[31:0];
            e.hi = r[31:0];
        end
        return e;
    endfunction

    // Called just after a rising edge; the next edge samples start.
    task automatic issue(input logic op, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        e     = model(op, a, b);
        e.due = cyc + 1 + ((op == OP_DIV && b == 32'd0) ? 1 : 34);
        sb_q.push_back(e);
        last_hi   = e.hi;
        last_lo   = e.lo;
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.op    = 1'($urandom_range(1));
        bus.a     = $urandom;
        bus.b     = $urandom;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain_timeout", 64'(sb_q.size()), 64'd0);
        sb_q.delete();
        @(posedge clk); #1;
    endtask

    task automatic check_hold();
        repeat (3) @(posedge clk);
        #1;
        check("hold_zhigh", bus.zhigh, last_hi);
        check("hold_zlow", bus.zlow, last_lo);
    endtask

    always @(negedge clk) begin
        if (!rst && bus.done) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL spurious_done actual=1 required=0 (cycle %0d)", cyc);
            end else begin
                mon_e = sb_q.pop_front();
                check("zhigh", bus.zhigh, mon_e.hi);
                check("zlow", bus.zlow, mon_e.lo);
                check("div_by_zero", bus.div_by_zero, mon_e.dz);
                check("latency", cyc, mon_e.due);
                check("busy_at_done", bus.busy, 1'b0);
            end
        end
    end

    initial begin
        logic        op;
        logic [31:0] a;
        logic [31:0] b;

        rst       = 1'b1;
        bus.start = 1'b0;
        bus.op    = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", bus.busy, 1'b0);
        check("rst_done", bus.done, 1'b0);
        check("rst_zhigh", bus.zhigh, 32'd0);
        check("rst_zlow", bus.zlow, 32'd0);
        check("rst_dbz", bus.div_by_zero, 1'b0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed corner cases
        issue(OP_MUL, 32'd7, 32'hFFFF_FFFD);         wait_idle(); check_hold();
        issue(OP_MUL, 32'h8000_0000, 32'h8000_0000); wait_idle(); check_hold();
        issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);         wait_idle(); check_hold();
        issue(OP_DIV, 32'd5, 32'd0);                 wait_idle();
        check("dbz_holds", bus.div_by_zero, 1'b1);
        issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF); wait_idle(); check_hold();
        issue(OP_DIV, 32'd3, 32'hFFFF_FFF9);         wait_idle();

        // Start while busy is ignored
        issue(OP_MUL, 32'h0123_4567, 32'hFEDC_BA98);
        repeat (9) @(posedge clk);
        #1;
        check("busy_mid_op", bus.busy, 1'b1);
        bus.start = 1'b1;
        bus.op    = OP_DIV;
        bus.a     = 32'd99;
        bus.b     = 32'd0;
        @(posedge clk); #1;
        bus.start = 1'b0;
        wait_idle();
        check_hold();

        // Clear in the middle of a multiply aborts it
        issue(OP_MUL, 32'h7654_3210, 32'h0BAD_F00D);
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        sb_q.delete();
        check("abort_busy", bus.busy, 1'b0);
        check("abort_done", bus.done, 1'b0);
        check("abort_zhigh", bus.zhigh, 32'd0);
        check("abort_zlow", bus.zlow, 32'd0);
        repeat (45) @(posedge clk);
        #1;

        // Clear wins over a simultaneous start
        rst       = 1'b1;
        bus.start = 1'b1;
        bus.op    = OP_MUL;
        bus.a     = 32'd3;
        bus.b     = 32'd4;
        @(posedge clk); #1;
        rst       = 1'b0;
        bus.start = 1'b0;
        @(posedge clk); #1;
        check("clear_priority_busy", bus.busy, 1'b0);
        repeat (40) @(posedge clk);
        #1;

        // Randomized operations
        for (int i = 0; i < 60; i++) begin
            op = 1'($urandom_range(1));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(7))
                0: b = 32'd0;
                1: b = 32'($signed($urandom_range(20)) - 10);
                2: a = 32'h8000_0000;
                3: b = 32'hFFFF_FFFF;
                default: ;
            endcase
            issue(op, a, b);
            if ($urandom_range(3) == 0) begin
                repeat ($urandom_range(5)) @(posedge clk);
                #1;
            end
            wait_idle();
        end
        check_hold();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 Clock  input  1  single system clock; all state changes on rising edge.
REQ-002 Clear  input  1  reset, synchronous and active-high.
REQ-003 start  input  1  request; sampled only in IDLE or DONE.
REQ-004 op  input  1  0 = signed multiply, 1 = signed divide; sampled with start.
REQ-005 a  input  32  Y-register operand (multiplicand / dividend); sampled with start.
REQ-006 b  input  32  BusMuxOut operand (multiplier / divisor); sampled with start.
REQ-007 busy  output  1  high while in CALC or FIX.
REQ-008 done  output  1  one-cycle pulse, high only in DONE.
REQ-009 zhigh  output  32  result high word, destined for Z_HI.
REQ-010 zlow  output  32  result low word, destined for Z_LO.
REQ-011 div_by_zero  output  1  set with done when op=1 and b=0; holds until the next accepted start.

Function
REQ-012 States SHALL be IDLE, CALC, FIX, DONE.
REQ-013 IDLE/DONE with start=1 SHALL latch op, a and b, then go to CALC; the zero-divisor case is the exception (REQ-019).
- Clear iteration counter; clear div_by_zero.
REQ-014 DONE with start=0 SHALL go to IDLE; start while busy SHALL be ignored.
REQ-015 CALC SHALL perform one iteration per cycle for exactly 32 cycles, then go to FIX.
- Multiply: radix-2 Booth on the 64-bit product.
- Divide: unsigned restoring on operand magnitudes, 33-bit partial remainder.
REQ-016 FIX (1 cycle) SHALL apply sign correction, load zhigh/zlow, then go to DONE.
REQ-017 Latency: done SHALL be high in the cycle beginning 34 edges after the start-sampling edge.
REQ-018 Result rules:
- Multiply: {zhigh,zlow} = full 64-bit signed product of a*b.
- Divide: zlow = quotient truncated toward zero; zhigh = remainder carrying the sign of the dividend.
REQ-019 Zero divisor (op=1, b=0):
- Next state is DONE directly; done is high 1 edge after start.
- zlow = 0xFFFFFFFF, zhigh = a, div_by_zero = 1.
REQ-020 0x80000000 / 0xFFFFFFFF SHALL give zlow = 0x80000000, zhigh = 0, div_by_zero = 0.
REQ-021 zhigh/zlow SHALL change only on entry to DONE and hold otherwise, including through IDLE.
REQ-022 Operand inputs SHALL be ignored after the sampling edge.

Reset
REQ-023 Clear=1 at an edge SHALL force IDLE and zero busy, done, div_by_zero, zhigh, zlow, counter and internal registers.
REQ-024 Clear mid-operation SHALL abort without producing a done pulse; Clear SHALL take priority over start.

Structure
REQ-025 Package mul_div_pkg SHALL hold:
- WIDTH=32 and ITER=32;
- op encodings OP_MUL=0 and OP_DIV=1;
- the state enum.
REQ-026 Single module; no sub-module; Booth and divide step logic inline, sharing one 64-bit accumulator and one 6-bit counter.

Verification
REQ-027 Signed multiply: op=0, a=7, b=0xFFFFFFFD -> after 34 cycles zhigh=0xFFFFFFFF, zlow=0xFFFFFFEB, done one cycle, busy low in DONE.
REQ-028 Largest-magnitude multiply: op=0, a=0x80000000, b=0x80000000 -> zhigh=0x40000000, zlow=0x00000000.
REQ-029 Signed divide: op=1, a=0xFFFFFFF9 (-7), b=2 -> zlow=0xFFFFFFFD (-3), zhigh=0xFFFFFFFF (-1), div_by_zero=0, latency 34.
REQ-030 Zero divisor: op=1, a=5, b=0 -> done 1 cycle after start, div_by_zero=1, zhigh=5, zlow=0xFFFFFFFF.
REQ-031 Overflow divide: op=1, a=0x80000000, b=0xFFFFFFFF -> zlow=0x80000000, zhigh=0.
REQ-032 Abort and busy-ignore:
- Clear at cycle 10 of a multiply -> next cycle busy=0, outputs 0, no done.
- start pulsed while busy -> ignored; the original result is unchanged at cycle 34.
